// File: rtl/cpu_logic_pkg.sv
// Shared encodings for the bit-serial logic unit: operation select and FSM state.
package cpu_logic_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/logic1.sv
// Single-bit logic cell: y = op(a, b).
module logic1
    import cpu_logic_pkg::*;
(
    input  logic a,
    input  logic b,
    input  op_e  op,
    output logic y
);

    always_comb begin
        y = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/bit_serial_logic16.sv
// Bit-serial bitwise logic unit: one result bit per cycle, LSB first, WIDTH cycles per op.
module bit_serial_logic16
    import cpu_logic_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state;
    op_e              op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             bit_y;

    logic1 u_logic1 (
        .a  (a_reg[cnt]),
        .b  (b_reg[cnt]),
        .op (op_reg),
        .y  (bit_y)
    );

    // Outputs are registered from the current state, so they trail the state by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_reg <= OP_AND;
            a_reg  <= '0;
            b_reg  <= '0;
            shreg  <= '0;
            cnt    <= '0;
            out    <= '0;
            zero   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            busy <= (state != IDLE);
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg  <= a;
                        b_reg  <= b;
                        op_reg <= op_e'(op);
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    shreg <= {bit_y, shreg[WIDTH-1:1]};
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    out   <= shreg;
                    zero  <= (shreg == '0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bit_serial_logic16.md
BIT_SERIAL_LOGIC16 -- requirements
Module: bit_serial_logic16

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, which sets the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation, sampled on the rising edge of clk.
REQ-005 The block SHALL have port op, input, 2 bits: operation select (00 AND, 01 OR, 10 XOR, 11 NOR).
REQ-006 The block SHALL have ports a and b, inputs, WIDTH bits each: the operands.
REQ-007 The block SHALL have port out, output, WIDTH bits: the registered result.
REQ-008 The block SHALL have port zero, output, 1 bit: high when out equals 0.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking a new result.

Function
REQ-011 The block SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-012 In IDLE, start=1 SHALL capture a, b and op into internal registers, clear the bit counter and move to RUN.
REQ-013 In RUN, the block SHALL process one bit per cycle, LSB first.
- bit i = op(a_reg[i], b_reg[i]).
- The result bit is shifted into an internal shift register from the MSB side.
REQ-014 The block SHALL stay in RUN for exactly WIDTH cycles, then move to DONE.
- The counter is clog2(WIDTH) bits wide and terminates at WIDTH-1.
- The counter SHALL NOT wrap back into RUN.
REQ-015 In DONE, for one cycle:
- done=1;
- out is loaded from the shift register;
- zero is set to (result==0).
The next state SHALL then be IDLE unconditionally.
REQ-016 Latency SHALL be fixed: when start is accepted at edge 0, done is high in the cycle after edge WIDTH+1, i.e. cycle 17 for WIDTH=16.
REQ-017 busy SHALL be high in RUN and DONE, and low in IDLE.
REQ-018 start SHALL be ignored in RUN and DONE, with no effect on the captured operands, op or counter.
REQ-019 Operand changes on a, b and op after capture SHALL NOT affect the in-flight result.
REQ-020 out and zero SHALL hold their last value until the next DONE cycle.
REQ-021 A start held high continuously SHALL begin a new operation at the first IDLE cycle after DONE.
REQ-022 Bitwise results SHALL involve no carry or overflow, and bit i of out SHALL depend only on bit i of a and b.

Reset
REQ-023 rst_n=0 SHALL, asynchronously and in any state including mid-RUN, force:
- state to IDLE;
- busy, done and zero to 0;
- out, the shift register, the operand registers and the counter to 0.
REQ-024 Reset release SHALL be synchronous to clk, and the first start after release SHALL be honoured normally.

Structure
REQ-025 The op encodings (OP_AND, OP_OR, OP_XOR, OP_NOR) and the state encoding SHALL be defined in a shared package, cpu_logic_pkg.
REQ-026 The per-bit function SHALL be one sub-module, logic1 (inputs a, b, op; output y), instantiated once.

Verification
REQ-027 The bench SHALL check: OR, a=0x00F0, b=0x0F0F, start at cycle 0 -> done in cycle 17 only, out=0x0FFF, zero=0.
REQ-028 The bench SHALL check: NOR, a=0xFFFF, b=0x0000 -> out=0x0000, zero=1.
REQ-029 The bench SHALL check: XOR, a=0xAAAA, b=0x5555 -> out=0xFFFF; and AND with the same operands -> out=0x0000, zero=1.
REQ-030 The bench SHALL check: an AND start with a=b=0x1234, then start=1 with new operands at cycle 5 -> ignored; out=0x1234 at done; busy high cycles 1-17.
REQ-031 The bench SHALL check: rst_n driven low at cycle 8 of RUN -> out=0, busy=0, done never pulses; a fresh OR of 0x0001 and 0x8000 after release -> out=0x8001.
REQ-032 The bench SHALL check: start held high for 40 cycles -> two complete operations, with done pulses 18 cycles apart.
